// File: rtl/sd_rx_nibble_packer_if.sv
// rtl/sd_rx_nibble_packer_if.sv - nibble input, FIFO read port and status bundle
interface sd_rx_nibble_packer_if #(
    parameter int DEPTH = 8
);
    logic [3:0]               nib_in;
    logic                     nib_we;
    logic                     blk_start;
    logic                     clr_ovf;
    logic                     rd_en;
    logic [31:0]              rd_data;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   level;
    logic [7:0]               word_cnt;
    logic                     partial;
    logic                     overflow;

    modport master (
        output nib_in, nib_we, blk_start, clr_ovf, rd_en,
        input  rd_data, empty, full, level, word_cnt, partial, overflow
    );

    modport slave (
        input  nib_in, nib_we, blk_start, clr_ovf, rd_en,
        output rd_data, empty, full, level, word_cnt, partial, overflow
    );
endinterface

// File: rtl/sd_rx_nibble_packer.sv
// rtl/sd_rx_nibble_packer.sv - packs received DAT nibbles into 32-bit words and queues them
module sd_rx_nibble_packer #(
    parameter int DEPTH = 8
) (
    input  logic                 sd_clk,
    input  logic                 rst,
    sd_rx_nibble_packer_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    // Seven nibbles are held here; the eighth goes straight into the pushed word.
    logic [2:0]    phase;
    logic [27:0]   asm_word;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [7:0]    word_cnt;
    logic          overflow;

    logic          is_full;
    logic          is_empty;
    logic          word_done;
    logic          pop;
    logic          push;
    logic          drop;
    logic [31:0]   done_word;

    // Push/pop decisions; a pop frees the slot a same-edge push needs when full.
    always_comb begin
        is_full   = (level == LEVEL_FULL);
        is_empty  = (level == '0);
        word_done = bus.nib_we && !bus.blk_start && (phase == 3'd7);
        pop       = bus.rd_en && !is_empty;
        push      = word_done && (!is_full || pop);
        drop      = word_done && is_full && !pop;
        done_word = {bus.nib_in, asm_word};
    end

    // Nibble assembly; blk_start realigns so a coincident nibble lands in bits [3:0].
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            phase    <= 3'd0;
            asm_word <= '0;
        end else if (bus.blk_start) begin
            asm_word <= {24'd0, (bus.nib_we ? bus.nib_in : 4'd0)};
            phase    <= bus.nib_we ? 3'd1 : 3'd0;
        end else if (bus.nib_we) begin
            if (phase == 3'd7) begin
                asm_word <= '0;
            end else begin
                for (int i = 0; i < 7; i++) begin
                    if (phase == 3'(i)) begin
                        asm_word[4*i +: 4] <= bus.nib_in;
                    end
                end
            end
            phase <= phase + 3'd1;
        end
    end

    // Word storage; contents survive reset, only pointers and level are cleared.
    always_ff @(posedge sd_clk) begin
        if (push) begin
            mem[wr_ptr] <= done_word;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Per-block accepted-word counter; dropped words are not counted.
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            word_cnt <= 8'd0;
        end else if (bus.blk_start) begin
            word_cnt <= 8'd0;
        end else if (push) begin
            word_cnt <= word_cnt + 8'd1;
        end
    end

    // Sticky overflow; a drop on the clearing edge wins.
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (bus.clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign bus.rd_data  = mem[rd_ptr];
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;
    assign bus.level    = level;
    assign bus.word_cnt = word_cnt;
    assign bus.partial  = (phase != 3'd0);
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_sd_rx_nibble_packer.sv
// tb/tb_sd_rx_nibble_packer.sv - self-checking bench for the nibble packer
module tb_sd_rx_nibble_packer;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic sd_clk = 1'b0;
    logic rst    = 1'b1;
    always #5 sd_clk = ~sd_clk;

    sd_rx_nibble_packer_if #(.DEPTH(DEPTH)) bus();
    sd_rx_nibble_packer #(.DEPTH(DEPTH)) dut (.sd_clk(sd_clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [31:0] m_q[$];
    logic [3:0]  m_nibs[$];
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;

    task automatic model_clear();
        m_q.delete();
        m_nibs.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] nib, input bit we, input bit bs, input bit clr, input bit rd);
        bit          pop;
        bit          done;
        logic [31:0] w;
        pop  = rd && (m_q.size() > 0);
        done = 1'b0;
        w    = 32'd0;
        if (bs) begin
            m_nibs.delete();
            m_cnt = 0;
        end
        if (we) begin
            m_nibs.push_back(nib);
            if (m_nibs.size() == 8) begin
                for (int i = 0; i < 8; i++) w = w + (32'(m_nibs[i]) << (4 * i));
                m_nibs.delete();
                done = 1'b1;
            end
        end
        if (clr) m_ovf = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (done) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(w);
                m_cnt = (m_cnt + 1) % 256;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic drive_cycle(input logic [3:0] nib, input bit we, input bit bs, input bit clr, input bit rd);
        @(negedge sd_clk);
        bus.nib_in    = nib;
        bus.nib_we    = we;
        bus.blk_start = bs;
        bus.clr_ovf   = clr;
        bus.rd_en     = rd;
        @(posedge sd_clk);
        model_step(nib, we, bs, clr, rd);
        #1;
    endtask

    task automatic do_reset();
        @(negedge sd_clk);
        rst           = 1'b1;
        bus.nib_in    = 4'd0;
        bus.nib_we    = 1'b0;
        bus.blk_start = 1'b0;
        bus.clr_ovf   = 1'b0;
        bus.rd_en     = 1'b0;
        model_clear();
        @(negedge sd_clk);
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rd_last, input bit clr_last);
        for (int i = 0; i < 8; i++)
            drive_cycle(w[4*i +: 4], 1'b1, 1'b0, clr_last && (i == 7), rd_last && (i == 7));
    endtask

    task automatic test_reset();
        bus.nib_in = 4'd0; bus.nib_we = 1'b0; bus.blk_start = 1'b0;
        bus.clr_ovf = 1'b0; bus.rd_en = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
        total++; if (bus.level !== '0) begin bad++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        total++; if (bus.word_cnt !== 8'd0) begin bad++; $display("FAIL reset_word_cnt: got %0d want 0", bus.word_cnt); end
        total++; if (bus.partial !== 1'b0) begin bad++; $display("FAIL reset_partial: got %b want 0", bus.partial); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        do_reset();
    endtask

    task automatic test_basic_word();
        do_reset();
        drive_cycle(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) drive_cycle(4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL basic_empty: got %b want 0", bus.empty); end
        total++; if (bus.rd_data !== 32'h87654321) begin bad++; $display("FAIL basic_data: got %h want 87654321", bus.rd_data); end
        total++; if (bus.word_cnt !== 8'd1) begin bad++; $display("FAIL basic_word_cnt: got %0d want 1", bus.word_cnt); end
        total++; if (bus.partial !== 1'b0) begin bad++; $display("FAIL basic_partial: got %b want 0", bus.partial); end
    endtask

    task automatic test_overflow();
        logic [31:0] w[11];
        logic [31:0] expect_rd[8];
        do_reset();
        for (int i = 0; i < 11; i++) w[i] = $urandom;
        drive_cycle(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_word(w[i], 1'b0, 1'b0);
        total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL ovf_full8: got %b want 1", bus.full); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", bus.overflow); end
        send_word(w[8], 1'b0, 1'b0);
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
        total++; if (bus.level !== LW'(8)) begin bad++; $display("FAIL ovf_level: got %0d want 8", bus.level); end
        total++; if (bus.word_cnt !== 8'd8) begin bad++; $display("FAIL ovf_word_cnt: got %0d want 8", bus.word_cnt); end
        drive_cycle(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
        send_word(w[9], 1'b1, 1'b0);
        total++; if (bus.level !== LW'(8)) begin bad++; $display("FAIL full_pushpop_level: got %0d want 8", bus.level); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL full_pushpop_ovf: got %b want 0", bus.overflow); end
        total++; if (bus.rd_data !== w[1]) begin bad++; $display("FAIL full_pushpop_head: got %h want %h", bus.rd_data, w[1]); end
        send_word(w[10], 1'b0, 1'b1);
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL drop_beats_clr: got %b want 1", bus.overflow); end
        for (int i = 0; i < 7; i++) expect_rd[i] = w[i+1];
        expect_rd[7] = w[9];
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus.rd_data !== expect_rd[i]) begin bad++; $display("FAIL ovf_drain%0d: got %h want %h", i, bus.rd_data, expect_rd[i]); end
            drive_cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL ovf_drained: got %b want 1", bus.empty); end
    endtask

    task automatic test_realign();
        do_reset();
        drive_cycle(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (bus.partial !== 1'b1) begin bad++; $display("FAIL realign_partial_before: got %b want 1", bus.partial); end
        drive_cycle(4'hA, 1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (bus.partial !== 1'b1) begin bad++; $display("FAIL realign_partial_after: got %b want 1", bus.partial); end
        for (int i = 1; i <= 7; i++) drive_cycle(4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (bus.rd_data !== 32'h7654321A) begin bad++; $display("FAIL realign_data: got %h want 7654321a", bus.rd_data); end
        total++; if (bus.word_cnt !== 8'd1) begin bad++; $display("FAIL realign_word_cnt: got %0d want 1", bus.word_cnt); end
        total++; if (bus.level !== LW'(1)) begin bad++; $display("FAIL realign_level: got %0d want 1", bus.level); end
    endtask

    task automatic test_empty_pop();
        logic [31:0] w;
        do_reset();
        drive_cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (bus.level !== '0) begin bad++; $display("FAIL empty_pop_level: got %0d want 0", bus.level); end
        w = $urandom;
        send_word(w, 1'b1, 1'b0);
        total++; if (bus.level !== LW'(1)) begin bad++; $display("FAIL empty_pushpop_level: got %0d want 1", bus.level); end
        total++; if (bus.rd_data !== w) begin bad++; $display("FAIL empty_pushpop_head: got %h want %h", bus.rd_data, w); end
        drive_cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL empty_after_pop: got %b want 1", bus.empty); end
    endtask

    task automatic test_stream();
        int sent;
        int popped;
        bit we;
        do_reset();
        drive_cycle(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        sent   = 0;
        popped = 0;
        for (int cyc = 0; cyc < 20000 && (sent < 2400 || !bus.empty); cyc++) begin
            we = (sent < 2400) && ($urandom_range(0, 3) != 0);
            if (!bus.empty) popped++;
            drive_cycle(4'($urandom_range(0, 15)), we, 1'b0, 1'b0, 1'b1);
            if (we) sent++;
            total++;
            if (bus.level !== LW'(m_q.size())) begin bad++; $display("FAIL stream_level: got %0d want %0d", bus.level, m_q.size()); end
            if (m_q.size() > 0) begin
                total++;
                if (bus.rd_data !== m_q[0]) begin bad++; $display("FAIL stream_data: got %h want %h", bus.rd_data, m_q[0]); end
            end
        end
        total++; if (popped != 300) begin bad++; $display("FAIL stream_popped: got %0d want 300", popped); end
        total++; if (bus.word_cnt !== 8'd44) begin bad++; $display("FAIL stream_word_cnt: got %0d want 44", bus.word_cnt); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL stream_overflow: got %b want 0", bus.overflow); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive_cycle(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                        $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3);
            total++;
            if (bus.level !== LW'(m_q.size()) || bus.empty !== (m_q.size() == 0) || bus.full !== (m_q.size() == DEPTH)) begin
                bad++; $display("FAIL rand_level: got %0d/%b/%b want %0d", bus.level, bus.empty, bus.full, m_q.size());
            end
            total++;
            if (bus.word_cnt !== 8'(m_cnt) || bus.partial !== (m_nibs.size() != 0) || bus.overflow !== m_ovf) begin
                bad++; $display("FAIL rand_status: got %0d/%b/%b want %0d/%b/%b", bus.word_cnt, bus.partial, bus.overflow,
                                m_cnt, m_nibs.size() != 0, m_ovf);
            end
            if (m_q.size() > 0) begin
                total++;
                if (bus.rd_data !== m_q[0]) begin bad++; $display("FAIL rand_data: got %h want %h", bus.rd_data, m_q[0]); end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_cycle(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_word($urandom, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (bus.level !== LW'(5) || bus.partial !== 1'b1) begin bad++; $display("FAIL arst_setup: got %0d/%b want 5/1", bus.level, bus.partial); end
        bus.nib_we = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (bus.level !== '0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin bad++; $display("FAIL arst_fifo: got %0d/%b/%b want 0/1/0", bus.level, bus.empty, bus.full); end
        total++; if (bus.partial !== 1'b0 || bus.word_cnt !== 8'd0 || bus.overflow !== 1'b0) begin bad++; $display("FAIL arst_status: got %b/%0d/%b want 0/0/0", bus.partial, bus.word_cnt, bus.overflow); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_overflow();
        test_realign();
        test_empty_pop();
        test_stream();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
